// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters write bursts of up to BURST
// beats into one shared FIFO, one owner at a time.
module fifo_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          busy
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]    BURST_C  = 8'(BURST);
  localparam logic [OW-1:0] LAST_RST = OW'(NUM_REQ - 1);

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       last_q, last_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [OW-1:0]       cand_s;
  logic [OW-1:0]       sel_s;
  logic                sel_found_s;
  logic                owner_req_s;
  logic                w_en_s;
  logic                last_beat_s;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    sel_found_s = 1'b0;
    sel_s       = '0;
    cand_s      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = OW'((int'(last_q) + k) % NUM_REQ);
      if (!sel_found_s && req[cand_s]) begin
        sel_found_s = 1'b1;
        sel_s       = cand_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  assign owner_req_s = req[owner_q];
  assign w_en_s      = rst_n & (state_q == SERVE) & owner_req_s & ~fifo_full;
  assign last_beat_s = ((cnt_q + 8'd1) == BURST_C);

  // Next-state logic for ownership, beat count and grant.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_found_s) begin
          gnt_d   = NUM_REQ'(1) << sel_s;
          owner_d = sel_s;
          cnt_d   = 8'd0;
          state_d = SERVE;
        end else begin
          gnt_d   = '0;
        end
      end
      SERVE: begin
        if (!owner_req_s) begin
          gnt_d   = '0;
          last_d  = owner_q;
          state_d = IDLE;
        end else if (w_en_s) begin
          cnt_d = cnt_q + 8'd1;
          if (last_beat_s) begin
            gnt_d   = '0;
            last_d  = owner_q;
            state_d = IDLE;
          end else begin
            state_d = SERVE;
          end
        end else begin
          // FIFO full: hold everything until the beat can go through.
          cnt_d = cnt_q;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q == SERVE);
  assign fifo_w_en = w_en_s;
  assign fifo_data = (state_q == SERVE) ?
                     req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: per-requester data scoreboard,
// cycle reference model, directed scenarios and a long random run.
module tb_fifo_rr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DW        = 8;
  localparam int BURST     = 4;
  localparam int LAT_BOUND = NUM_REQ * (BURST + 1);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*DW-1:0]  req_data;
  logic                   fifo_full;
  logic [NUM_REQ-1:0]     gnt;
  logic                   fifo_w_en;
  logic [DW-1:0]          fifo_data;
  logic                   busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0]      src_q [NUM_REQ][$];
  logic [NUM_REQ-1:0] glog [$];
  logic [NUM_REQ-1:0] drop_mask;
  logic [NUM_REQ-1:0] prev_gnt;
  int                 wr_cnt;

  // reference model state
  bit                 m_busy;
  logic [NUM_REQ-1:0] m_gnt;
  int                 m_owner;
  int                 m_last;
  int                 m_cnt;
  bit                 model_valid;

  bit lat_en;
  int wait_cnt [NUM_REQ];
  int max_wait;

  logic [NUM_REQ-1:0] exp_b [5];

  fifo_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .BURST(BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .fifo_full (fifo_full),
    .fifo_w_en (fifo_w_en),
    .fifo_data (fifo_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] glog_at(input int k);
    return (k < glog.size()) ? glog[k] : '0;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        req[i]              = !drop_mask[i];
        req_data[i*DW +: DW] = src_q[i][0];
      end else begin
        req[i]              = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic model_edge();
    int c;
    if (!rst_n) begin
      m_busy = 1'b0; m_gnt = '0; m_cnt = 0; m_last = NUM_REQ - 1;
    end else if (!m_busy) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (m_last + k) % NUM_REQ;
        if (req[c]) begin
          m_owner = c; m_gnt = '0; m_gnt[c] = 1'b1; m_cnt = 0; m_busy = 1'b1;
          break;
        end
      end
    end else if (!req[m_owner]) begin
      m_busy = 1'b0; m_gnt = '0; m_last = m_owner;
    end else if (!fifo_full) begin
      m_cnt++;
      if (m_cnt == BURST) begin
        m_busy = 1'b0; m_gnt = '0; m_last = m_owner;
      end
    end
  endtask

  task automatic step();
    logic          exp_wen;
    logic [DW-1:0] exp_data;
    int            own;
    bit            stall;
    drive_inputs();
    @(negedge clk);
    if (model_valid) begin
      exp_wen  = rst_n && m_busy && req[m_owner] && !fifo_full;
      exp_data = m_busy ? req_data[m_owner*DW +: DW] : '0;
      check_val("gnt", 32'(gnt), 32'(m_gnt));
      check_val("busy", 32'(busy), 32'(m_busy));
      check_val("w_en", 32'(fifo_w_en), 32'(exp_wen));
      check_val("data", 32'(fifo_data), 32'(exp_data));
      check_val("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check_val("wr_while_full", 32'(fifo_w_en & fifo_full), 32'd0);
    end
    if (fifo_w_en) begin
      wr_cnt++;
      own = -1;
      for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) own = i;
      if (own < 0)
        check_val("sb_owner", 32'(gnt != '0), 32'd1);
      else if (src_q[own].size() == 0)
        check_val("sb_empty", 32'(src_q[own].size()), 32'd1);
      else
        check_val("sb_data", 32'(fifo_data), 32'(src_q[own].pop_front()));
    end
    if (gnt != '0 && prev_gnt == '0) glog.push_back(gnt);
    prev_gnt = gnt;
    if (lat_en) begin
      stall = busy && ((gnt & req) != '0) && fifo_full;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && !gnt[i]) begin
          if (!stall) wait_cnt[i]++;
        end else begin
          wait_cnt[i] = 0;
        end
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
    @(posedge clk);
    model_edge();
    model_valid = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic push_items(input int r, input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) src_q[r].push_back(base + DW'(k));
  endtask

  task automatic drain();
    int left;
    drop_mask = '0;
    fifo_full = 1'b0;
    for (int c = 0; c < 400; c++) begin
      left = 0;
      for (int i = 0; i < NUM_REQ; i++) left += src_q[i].size();
      if (left == 0 && !busy) break;
      step();
    end
    left = 0;
    for (int i = 0; i < NUM_REQ; i++) left += src_q[i].size();
    check_val("drain_left", 32'(left), 32'd0);
  endtask

  initial begin
    exp_b = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0; fifo_full = 1'b0; drop_mask = '0;
    req = '0; req_data = '0; prev_gnt = '0; wr_cnt = 0;
    model_valid = 1'b0; lat_en = 1'b0; max_wait = 0;
    m_busy = 1'b0; m_gnt = '0; m_owner = 0; m_last = NUM_REQ - 1; m_cnt = 0;
    for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;

    do_reset();
    check_val("rst_gnt", 32'(gnt), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);

    // single requester 2, full burst
    push_items(2, 4, 8'hA0);
    glog.delete(); wr_cnt = 0;
    repeat (8) step();
    check_val("a_ngrants", 32'(glog.size()), 32'd1);
    check_val("a_gnt", 32'(glog_at(0)), 32'b0100);
    check_val("a_writes", 32'(wr_cnt), 32'd4);
    check_val("a_gnt_end", 32'(gnt), 32'd0);
    check_val("a_busy_end", 32'(busy), 32'd0);

    // all four requesting: strict rotation
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) push_items(i, 8, DW'(8'h10 * (i + 1)));
    glog.delete();
    for (int c = 0; c < 60 && glog.size() < 5; c++) step();
    for (int k = 0; k < 5; k++) check_val($sformatf("b_order%0d", k), 32'(glog_at(k)), 32'(exp_b[k]));
    drain();

    // owner 1 stalled by a full FIFO after beat 2
    do_reset();
    push_items(1, 4, 8'h50);
    wr_cnt = 0;
    repeat (3) step();
    check_val("c_beats_pre", 32'(wr_cnt), 32'd2);
    fifo_full = 1'b1;
    repeat (3) begin
      step();
      check_val("c_stall_gnt", 32'(gnt), 32'b0010);
      check_val("c_stall_wen", 32'(fifo_w_en), 32'd0);
    end
    check_val("c_beats_stall", 32'(wr_cnt), 32'd2);
    fifo_full = 1'b0;
    repeat (3) step();
    check_val("c_beats_total", 32'(wr_cnt), 32'd4);
    check_val("c_gnt_end", 32'(gnt), 32'd0);

    // owner 3 drops after one beat; search restarts at 0
    push_items(3, 4, 8'h70);
    step();
    step();
    check_val("d_gnt3", 32'(gnt), 32'b1000);
    check_val("d_beats", 32'(wr_cnt), 32'd5);
    drop_mask = 4'b1000;
    push_items(0, 2, 8'h01);
    push_items(2, 2, 8'h21);
    step();
    check_val("d_gnt_drop", 32'(gnt), 32'd0);
    step();
    check_val("d_next", 32'(gnt), 32'b0001);
    drain();

    // reset in the middle of a burst
    push_items(2, 4, 8'hC0);
    repeat (3) step();
    check_val("e_gnt2", 32'(gnt), 32'b0100);
    rst_n = 1'b0;
    step();
    check_val("e_rst_gnt", 32'(gnt), 32'd0);
    check_val("e_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    push_items(0, 2, 8'hE0);
    step();
    check_val("e_first", 32'(gnt), 32'b0001);
    drain();

    // random traffic with FIFO back-pressure
    lat_en = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      fifo_full = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0)
          push_items(i, int'($urandom_range(1, 6)), DW'($urandom));
        drop_mask[i] = ($urandom_range(0, 9) == 0);
      end
      step();
    end
    lat_en = 1'b0;
    check_val("rand_latency", 32'(max_wait <= LAT_BOUND), 32'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
